jt51_cmd_player: RTL and testbench
==================================

// Module: jt51_cmd_player
// PURPOSE
// Bus initiator for the jt51 CPU port: consumes a stream of register-write and
// wait-for-samples commands (e.g. a VGM-style register dump) and drives cs_n/wr_n/a0/din
// with correct YM2151 timing, honouring the busy flag on dout[7].
// Sits between a command source (ROM/FIFO/bench) and the jt51 CPU port, on the jt51 clock domain.
// PARAMETERS
// WR_HOLD   2     cen ticks wr_n is held low per address/data strobe (>=1)
// BUSY_TO   1023  cen ticks of busy polling before timeout_err is set (>=1)
// PORTS
// clk          in   1   system clock (48 MHz in the jt51 benches)
// rst          in   1   synchronous, active-high reset
// cen          in   1   bus pacing enable (jt51 cen, 3.58 MHz rate); all bus timing in cen ticks
// cmd_valid    in   1   command present
// cmd_ready    out  1   player accepts command this cycle (valid&ready = accept)
// cmd_op       in   1   0=WRITE, 1=WAIT
// cmd_addr     in   8   WRITE: register address; WAIT: count[15:8]
// cmd_data     in   8   WRITE: register value;   WAIT: count[7:0]
// sample       in   1   jt51 sample strobe; rising edges counted by WAIT
// cs_n         out  1   chip select to jt51
// wr_n         out  1   write strobe to jt51
// a0           out  1   0=address port, 1=data port
// dout         out  8   data bus to jt51 din
// din          in   8   jt51 dout; bit 7 = busy
// busy_play    out  1   high whenever state != IDLE
// timeout_err  out  1   sticky: a busy poll hit BUSY_TO
// BEHAVIOUR
// - Reset: cs_n=1, wr_n=1, a0=0, dout=0x00, cmd_ready=0, busy_play=0, timeout_err=0, state IDLE.
//   cmd_ready rises the first clk after rst deasserts. rst mid-command aborts at once:
//   next edge wr_n=1, cs_n=1, state IDLE; no partial write completed afterwards.
// - cmd_ready is registered; high only in IDLE; drops the cycle after an accept.
//   Command fields are latched on accept; inputs may change afterwards.
// - All bus outputs are registered and change only on clk edges where cen=1.
// - WRITE FSM (states advance on cen ticks):
//   POLL: cs_n=0, wr_n=1, a0=1. First tick after entry is a settle tick (din ignored);
//         thereafter leave when din[7]=0, or when poll tick count reaches BUSY_TO
//         (set timeout_err, proceed anyway).
//   ADDR: a0=0, dout=addr, wr_n=0 for WR_HOLD ticks.
//   GAP:  wr_n=1 for 1 tick (a0, dout held).
//   DATA: a0=1, dout=data, wr_n=0 for WR_HOLD ticks.
//   REL:  wr_n=1, cs_n=1 for 1 tick, then IDLE.
//   Total with busy=0 from start: 2+WR_HOLD+1+WR_HOLD+1 cen ticks.
// - WAIT: count = {cmd_addr,cmd_data}. count=0 -> back to IDLE next clk.
//   Else count sample rising edges (sample registered, edge = s & ~s_d; no cen gating);
//   IDLE the clk after the count-th edge. Edge detector runs in all states,
//   so an edge in the accept cycle is not counted. Bus idle (cs_n=1,wr_n=1) during WAIT.
// - Poll counter 10+ bits wide (clog2(BUSY_TO+1)), saturates, cleared on POLL entry.
//   Hold counter clog2(WR_HOLD+1). Wait counter 16 bits, decrements per edge.
// - timeout_err cleared only by rst.
// STRUCTURE
// - Shared package jt51_cmd_pkg: OP_WRITE/OP_WAIT constants, state encoding
//   (IDLE,POLL,ADDR,GAP,DATA,REL,WAIT), busy bit index (7).
// - Single flat module; no sub-module. Sample edge detect and counters inline.
// TESTING
// - Reset: hold rst 4 clk -> cs_n=1, wr_n=1, a0=0, dout=0, cmd_ready=0;
//   cmd_ready=1 one clk after release.
// - WRITE 0x08/0x78, din=0x00, WR_HOLD=2 -> a0=0,dout=08 wr_n low 2 ticks; 1 gap tick;
//   a0=1,dout=78 wr_n low 2 ticks; cmd_ready back after 8 cen ticks total.
// - WRITE with din[7]=1 for 50 ticks -> no wr_n low before din[7] falls; ADDR strobe
//   begins the tick after busy clears; timeout_err stays 0.
// - din[7] stuck at 1 -> timeout_err=1 after 1023 poll ticks, write still issued.
// - WAIT 3 -> cmd_ready returns the clk after 3rd sample rising edge;
//   WAIT 0 -> cmd_ready returns 2 clk after accept; no bus activity.
// - rst asserted while wr_n=0 in DATA -> wr_n=1, cs_n=1 next clk; after release
//   new WRITE 0x20/0xC7 runs a full clean sequence.

Source files
------------

// File: rtl/jt51_cmd_pkg.sv
// Shared definitions for the jt51 command player: opcodes, FSM state encoding
// and the busy flag position on the jt51 data output.
package jt51_cmd_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_WAIT  = 1'b1;

  localparam int BUSY_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POLL = 3'd1,
    S_ADDR = 3'd2,
    S_GAP  = 3'd3,
    S_DATA = 3'd4,
    S_REL  = 3'd5,
    S_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/jt51_cmd_player.sv
// Bus initiator for the jt51 CPU port: plays register-write and wait-for-samples
// commands, pacing every bus transition on cen and honouring the busy flag.
module jt51_cmd_player
  import jt51_cmd_pkg::*;
#(
  parameter int WR_HOLD = 2,
  parameter int BUSY_TO = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       sample,
  output logic       cs_n,
  output logic       wr_n,
  output logic       a0,
  output logic [7:0] dout,
  input  logic [7:0] din,
  output logic       busy_play,
  output logic       timeout_err,
  output logic [2:0] dbg_state
);

  localparam int PW = $clog2(BUSY_TO + 1);
  localparam int HW = $clog2(WR_HOLD + 1);

  // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
  // cmd_ready is registered and only offered while the FSM sits in IDLE.
  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [HW-1:0] hold_cnt;
  logic [15:0]   wait_cnt;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic          s_r;
  logic          s_d;
  logic          smp_edge;

  assign smp_edge  = s_r & ~s_d;
  assign busy_play = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      cs_n        <= 1'b1;
      wr_n        <= 1'b1;
      a0          <= 1'b0;
      dout        <= 8'h00;
      timeout_err <= 1'b0;
      poll_cnt    <= '0;
      hold_cnt    <= '0;
      wait_cnt    <= 16'd0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      s_r         <= 1'b0;
      s_d         <= 1'b0;
    end else begin
      s_r <= sample;
      s_d <= s_r;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            wait_cnt  <= {cmd_addr, cmd_data};
            poll_cnt  <= '0;
            state     <= (cmd_op == OP_WAIT) ? S_WAIT : S_POLL;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_POLL: if (cen) begin
          cs_n <= 1'b0;
          wr_n <= 1'b1;
          a0   <= 1'b1;
          // The first tick only settles the bus; din is trusted from the next one.
          if (poll_cnt == '0) begin
            poll_cnt <= PW'(1);
          end else if (!din[BUSY_BIT] || poll_cnt >= PW'(BUSY_TO)) begin
            if (din[BUSY_BIT]) timeout_err <= 1'b1;
            a0       <= 1'b0;
            dout     <= addr_q;
            wr_n     <= 1'b0;
            hold_cnt <= '0;
            state    <= S_ADDR;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        S_ADDR: if (cen) begin
          if (hold_cnt == HW'(WR_HOLD - 1)) begin
            wr_n  <= 1'b1;
            state <= S_GAP;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_GAP: if (cen) begin
          a0       <= 1'b1;
          dout     <= data_q;
          wr_n     <= 1'b0;
          hold_cnt <= '0;
          state    <= S_DATA;
        end
        S_DATA: if (cen) begin
          if (hold_cnt == HW'(WR_HOLD - 1)) begin
            wr_n  <= 1'b1;
            cs_n  <= 1'b1;
            state <= S_REL;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_REL: if (cen) begin
          state <= S_IDLE;
        end
        S_WAIT: begin
          if (wait_cnt == 16'd0) begin
            state <= S_IDLE;
          end else if (smp_edge) begin
            wait_cnt <= wait_cnt - 16'd1;
            if (wait_cnt == 16'd1) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_cmd_player.sv
// Randomised scoreboard bench for jt51_cmd_player: strobes, command latency,
// wait counting, busy/timeout handling and mid-command reset.
module tb_jt51_cmd_player;
  localparam int WR_HOLD = 2;
  localparam int BUSY_TO = 1023;
  localparam int BOUND   = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       sample = 1'b0;
  logic       cs_n, wr_n, a0;
  logic [7:0] dout;
  logic [7:0] din;
  logic       busy_play, timeout_err;
  logic [2:0] dbg_state;

  logic [6:0] din_noise = 7'h00;
  int         busy_left = 0;
  assign din = {busy_left > 0, din_noise};

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];
  int         tick_q[$];
  bit         tmo_q[$];

  jt51_cmd_player #(.WR_HOLD(WR_HOLD), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sample(sample),
    .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .dout(dout), .din(din),
    .busy_play(busy_play), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // background stimulus: cen pacing, sample toggling, din noise bits
  initial forever begin
    @(negedge clk);
    cen       = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 2) == 0) sample = ~sample;
    din_noise = 7'($urandom);
  end

  // busy model: din[7] stays high for busy_left cen ticks
  initial begin
    logic c;
    forever begin
      @(posedge clk);
      c = cen;
      #1;
      if (c && busy_left > 0) busy_left--;
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_a0", a0, 0);
    check("rst_dout", dout, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy_play", busy_play, 0);
    check("rst_timeout_err", timeout_err, 0);
    busy_left = 0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("ready_bound", 0, 1);
  endtask

  task automatic issue(input logic op, input logic [7:0] addr, input logic [7:0] data,
                       input int b, input bit wait_done);
    int pt;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    if (op == 1'b0) begin
      exp_q.push_back({1'b0, addr});
      exp_q.push_back({1'b1, data});
      pt = (b + 1 < 2) ? 2 : b + 1;
      if (pt > BUSY_TO + 1) pt = BUSY_TO + 1;
      tick_q.push_back(pt + 2 * WR_HOLD + 2);
      tmo_q.push_back(b > BUSY_TO);
    end
    wait_ready();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_data  = 8'($urandom);
    if (op == 1'b0) busy_left = b;
    if (wait_done) begin
      wait_ready();
      busy_left = 0;
    end
  endtask

  // monitor + scoreboard
  int   cyc = 0, low_ticks = 0, wr_ticks = 0, w_left = 0, w_exp = -1;
  bit   wr_act = 0, w_act = 0, w_bus = 0, tmo_model = 0;
  logic p_cs = 1, p_wr = 1, p_a0 = 0, p_rdy = 0, p_smp = 0;
  logic [7:0] p_dout = 0;
  logic e_cen, e_rst, e_val, e_op, e_smp, e_busy;
  logic [15:0] e_cnt;

  initial forever begin
    @(posedge clk);
    cyc++;
    e_cen = cen; e_rst = rst; e_val = cmd_valid; e_op = cmd_op;
    e_cnt = {cmd_addr, cmd_data}; e_smp = sample; e_busy = din[7];
    #1;
    if (e_rst) begin
      exp_q.delete(); tick_q.delete(); tmo_q.delete();
      wr_act = 0; w_act = 0; tmo_model = 0;
    end else begin
      if (p_rdy && e_val) begin
        if (e_op == 1'b0) begin
          wr_act = 1; wr_ticks = 0;
        end else begin
          w_act = 1; w_left = e_cnt; w_bus = 0;
          w_exp = (e_cnt == 0) ? cyc + 2 : -1;
        end
      end else begin
        if (wr_act) begin
          if (cmd_ready) begin
            wr_act = 0;
            if (tick_q.size() == 0) check("write_expected", 0, 1);
            else check("write_ticks", wr_ticks, tick_q.pop_front());
            if (tmo_q.size() != 0) tmo_model = tmo_model | tmo_q.pop_front();
            check("timeout_flag", timeout_err, tmo_model);
            check("strobes_done", exp_q.size(), 0);
            check("busy_play_idle", busy_play, 0);
          end else if (e_cen) begin
            wr_ticks++;
          end
        end
        if (w_act) begin
          if (cmd_ready) begin
            w_act = 0;
            check("wait_done_cycle", cyc, w_exp);
            check("wait_bus_idle", w_bus, 0);
          end else if (!cs_n || !wr_n) begin
            w_bus = 1;
          end
        end
      end
      if (w_act && e_smp && !p_smp && w_left > 0) begin
        w_left--;
        if (w_left == 0) w_exp = cyc + 2;
      end
      if ({cs_n, wr_n, a0, dout} !== {p_cs, p_wr, p_a0, p_dout})
        check("bus_on_cen", e_cen, 1);
      if (p_wr && !wr_n) begin
        low_ticks = 0;
        check("strobe_cs_n", cs_n, 0);
        if (!a0) check("addr_after_busy", (!e_busy) || timeout_err, 1);
      end
      if (!p_wr && e_cen) low_ticks++;
      if (!p_wr && wr_n) begin
        if (exp_q.size() == 0) check("strobe_expected", 0, 1);
        else check("strobe_a0_dout", {a0, dout}, exp_q.pop_front());
        check("strobe_len", low_ticks, WR_HOLD);
      end
    end
    p_cs = cs_n; p_wr = wr_n; p_a0 = a0; p_dout = dout; p_rdy = cmd_ready; p_smp = e_smp;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // main sequence and final report
  initial begin
    int n;
    do_reset();
    issue(1'b0, 8'h08, 8'h78, 0, 1);
    issue(1'b0, 8'h10, 8'h3C, 50, 1);
    check("no_timeout_busy50", timeout_err, 0);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0)
        issue(1'b1, 8'h00, 8'($urandom_range(0, 4)), 0, 1);
      else
        issue(1'b0, 8'($urandom), 8'($urandom),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12)), 1);
    end
    issue(1'b1, 8'h00, 8'h03, 0, 1);
    issue(1'b1, 8'h00, 8'h00, 0, 1);
    issue(1'b0, 8'h28, 8'h4A, 5000, 1);
    check("timeout_set", timeout_err, 1);
    issue(1'b0, 8'h30, 8'h55, 0, 0);
    n = 0;
    while (!(wr_n == 1'b0 && a0 == 1'b1) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("reach_data_strobe", n < BOUND, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wr_n", wr_n, 1);
    check("abort_cs_n", cs_n, 1);
    check("abort_busy_play", busy_play, 0);
    do_reset();
    issue(1'b0, 8'h20, 8'hC7, 0, 1);
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_timeout_clear", timeout_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
